// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Optional direct HI/LO write port enabled by defining MULTDIV_MTHILO_EN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
`ifdef MULTDIV_MTHILO_EN
  input  logic             hilo_write_i,
  input  logic             hilo_sel_i,
  input  logic [WIDTH-1:0] hilo_data_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // state  | meaning
  // IDLE   | waiting for start; HI/LO stable
  // CALC   | one shift-add / shift-subtract step per cycle
  // FIX    | sign correction for signed ops
  // DONE   | commit HI/LO, pulse done
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             is_signed_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             dbz_pend_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opb_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    a_neg = ~op_i[0] & operand_a_i[WIDTH-1];
    b_neg = ~op_i[0] & operand_b_i[WIDTH-1];
    a_abs = a_neg ? -operand_a_i : operand_a_i;
    b_abs = b_neg ? -operand_b_i : operand_b_i;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   step_hi_d;
  logic [WIDTH-1:0]   step_lo_d;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi_d;
  logic [WIDTH-1:0]   fix_lo_d;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // After a successful subtract the remainder is below the divisor, so W bits suffice.
    div_sub   = div_shift[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      step_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      {step_hi_d, step_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_neg = -{acc_hi_q, acc_lo_q};
    fix_hi_d = acc_hi_q;
    fix_lo_d = acc_lo_q;
    if (is_signed_q) begin
      if (!is_div_q) begin
        if (sign_a_q ^ sign_b_q) {fix_hi_d, fix_lo_d} = prod_neg;
      end else begin
        if (sign_a_q ^ sign_b_q) fix_lo_d = -acc_lo_q;
        if (sign_a_q)            fix_hi_d = -acc_hi_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      dbz_pend_q  <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opb_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            is_div_q    <= op_i[1];
            is_signed_q <= ~op_i[0];
            sign_a_q    <= a_neg;
            sign_b_q    <= b_neg;
            busy_q      <= 1'b1;
            if (op_i[1] && (operand_b_i == '0)) begin
              dbz_pend_q <= 1'b1;
              acc_hi_q   <= operand_a_i;
              acc_lo_q   <= '1;
              state_q    <= S_DONE;
            end else begin
              dbz_pend_q <= 1'b0;
              acc_hi_q   <= '0;
              acc_lo_q   <= a_abs;
              opb_q      <= b_abs;
              cnt_q      <= CW'(WIDTH);
              state_q    <= S_CALC;
            end
          end
`ifdef MULTDIV_MTHILO_EN
          else if (hilo_write_i) begin
            if (hilo_sel_i) hi_q <= hilo_data_i;
            else            lo_q <= hilo_data_i;
          end
`endif
        end
        S_CALC: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          acc_hi_q <= fix_hi_d;
          acc_lo_q <= fix_lo_d;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          hi_q    <= acc_hi_q;
          lo_q    <= acc_lo_q;
          done_q  <= 1'b1;
          dbz_q   <= dbz_pend_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
